memory_cycle: RTL and testbench
===============================

// Module: memory_cycle
// PURPOSE
//  MEM stage of the 5-stage RV32I pipeline; consumes the E->M pipeline register outputs.
//  Holds byte-addressable data memory and performs SB/SH/SW and LB/LH/LW/LBU/LHU.
//  Registers all results into the M->W pipeline register.
//  Drives the writeback result mux ResultW back to the register file.
// PARAMETERS
//  DMEM_WORDS  1024  data memory depth in 32-bit words; power of 2
//  AW          10    word-index width = log2(DMEM_WORDS)
// PORTS
//  clk         in   1   clock
//  rst         in   1   reset, asynchronous, active-high
//  ALUResultM  in   32  effective address / ALU result
//  WriteDataM  in   32  store data (rs2)
//  PCPlus4M    in   32  link value
//  InstrM      in   32  instruction; [14:12] funct3 selects access size/sign
//  RdM         in   5   destination register
//  RegWriteM   in   1   register write enable
//  MemWriteM   in   1   store enable
//  ResultSrcM  in   2   00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU)
//  ALUResultW  out  32  registered ALU result
//  ReadDataW   out  32  registered extended load data
//  PCPlus4W    out  32  registered link value
//  RdW         out  5   registered destination
//  RegWriteW   out  1   registered write enable
//  ResultSrcW  out  2   registered result select
//  ResultW     out  32  combinational writeback mux of W registers
//  MisalignW   out  1   registered misaligned-access flag (0 when macro absent)
// BEHAVIOUR
//  - Word index = ALUResultM[AW+1:2]; upper address bits ignored (wraps modulo DMEM_WORDS).
//  - Byte offset off = ALUResultM[1:0].
//  - Store: synchronous write at posedge clk when MemWriteM=1 and rst=0.
//    funct3 000 SB: lane off <= WriteDataM[7:0].
//    funct3 001 SH: lanes off[1]*2 +: 2 <= WriteDataM[15:0].
//    funct3 010 SW: all 4 lanes.
//    Other funct3: no write.
//  - Load: combinational read of the addressed word, lane select by off, then:
//    000 LB sign-extend; 100 LBU zero-extend; 001 LH sign-extend; 101 LHU zero-extend;
//    010 LW full word; others -> 0.
//  - Store then load to the same word in the next cycle returns the new data (write-first by time).
//  - Latency: M inputs appear on W outputs 1 clk later; ResultW is valid in the same cycle as the W regs.
//  - ResultW: 01 -> ReadDataW; 10 -> PCPlus4W; 00/11 -> ALUResultW.
//  - Reset: all W registers incl. MisalignW = 0, so ResultW = 0.
//    Memory contents are NOT reset; writes are blocked while rst=1.
//  - rst asserted mid-store: no write occurs on any edge where rst=1.
//  - RegWriteM and MemWriteM are not cross-checked; the stage passes them through as given.
// CONFIGURATION
//  MEM_MISALIGN_CHECK_EN defined:
//    Misaligned = (SH/LH/LHU with off[0]=1) or (SW/LW with off!=0).
//    Misaligned store is suppressed (no lanes written).
//    Misaligned load gives ReadDataW = 0.
//    MisalignW is set 1 for one cycle with the W registers.
//    RegWriteW is forced to 0 for a misaligned load.
//  MEM_MISALIGN_CHECK_EN undefined:
//    off[0] ignored for halves; off ignored for words (aligned-down access).
//    MisalignW is tied 0.
// STRUCTURE
//  - Shared pipeline package (rv_pkg): funct3 load/store constants (F3_B,F3_H,F3_W,F3_BU,F3_HU),
//    ResultSrc encodings (RES_ALU,RES_MEM,RES_PC4).
//  - One sub-module: data_mem (byte-lane write-enable array, async read, DMEM_WORDS/AW params).
//  - Load extension, MW register and result mux stay in memory_cycle.
// TESTING
//  1 Reset: hold rst 3 clk -> all W outputs 0, ResultW=0; release, no memory change.
//  2 SW 0xDEADBEEF @0x10, then LW @0x10 with ResultSrc=01, Rd=5 -> ReadDataW=ResultW=0xDEADBEEF, RdW=5.
//  3 SB 0x80 @0x13 over 0x00000000, then:
//    LB @0x13 -> 0xFFFFFF80; LBU -> 0x00000080; LW @0x10 -> 0x80000000.
//  4 SH 0x8001 @0x22, then LH @0x22 -> 0xFFFF8001; LHU -> 0x00008001.
//    Low half of the word is unchanged.
//  5 Address wrap: SW 0x12345678 @(DMEM_WORDS*4+0x4), then LW @0x4 -> 0x12345678.
//  6 Misalign (macro on): SW @0x11 -> memory unchanged, MisalignW=1.
//    LW @0x11 -> ReadDataW=0, RegWriteW=0.
//    Macro off: same SW writes word 0x10.
//    Also check: ResultSrc=10 with PCPlus4M=0x104 -> ResultW=0x104.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I pipeline definitions: load/store funct3 codes, writeback select
// encodings and the M->W pipeline register layout.
package rv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] read_data;
        logic [31:0] pc_plus4;
        logic [4:0]  rd;
        logic        reg_write;
        logic [1:0]  result_src;
        logic        misalign;
    } mw_reg_t;

endpackage

// File: rtl/memory_cycle_if.sv
// E->M inputs and M->W outputs of the MEM stage, bundled for the stage and its driver.
interface memory_cycle_if;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] PCPlus4M;
    logic [31:0] InstrM;
    logic [4:0]  RdM;
    logic        RegWriteM;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;

    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;
    logic [4:0]  RdW;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ResultW;
    logic        MisalignW;

    modport master (
        output ALUResultM, WriteDataM, PCPlus4M, InstrM, RdM, RegWriteM, MemWriteM, ResultSrcM,
        input  ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW, ResultSrcW, ResultW, MisalignW
    );

    modport slave (
        input  ALUResultM, WriteDataM, PCPlus4M, InstrM, RdM, RegWriteM, MemWriteM, ResultSrcM,
        output ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW, ResultSrcW, ResultW, MisalignW
    );
endinterface

// File: rtl/memory_cycle_data_mem.sv
// Byte-addressable data memory: one 8-bit array per lane, per-lane write enable,
// asynchronous read of the addressed word. Contents are never reset.
module data_mem #(
    parameter int DMEM_WORDS = 1024,
    parameter int AW         = 10
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane [DMEM_WORDS];

            always_ff @(posedge clk) begin
                if (we[gi]) begin
                    lane[addr] <= wdata[gi*8 +: 8];
                end
            end

            assign rdata[gi*8 +: 8] = lane[addr];
        end
    endgenerate

endmodule

// File: rtl/memory_cycle.sv
// MEM stage of the 5-stage RV32I pipeline: data memory access, load extension,
// M->W register and writeback mux. Optional macro: MEM_MISALIGN_CHECK_EN.
module memory_cycle
    import rv_pkg::*;
#(
    parameter int DMEM_WORDS = 1024,
    parameter int AW         = 10
) (
    input  logic           clk,
    input  logic           rst,
    memory_cycle_if.slave  bus
);

    logic [AW-1:0] word_idx;
    logic [1:0]    off;
    logic [2:0]    funct3;
    logic          is_load;
    logic          mis_store;
    logic          mis_load;
    logic [3:0]    lane_we;
    logic [31:0]   wdata;
    logic [31:0]   rword;
    logic [31:0]   rshift;
    logic [15:0]   rhalf;
    logic [31:0]   load_data;
    logic          unused_bits;
    mw_reg_t       mw_next;
    mw_reg_t       mw_reg;

    assign word_idx    = bus.ALUResultM[AW+1:2];
    assign off         = bus.ALUResultM[1:0];
    assign funct3      = bus.InstrM[14:12];
    assign is_load     = (bus.ResultSrcM == RES_MEM);
    assign unused_bits = ^{bus.ALUResultM[31:AW+2], bus.InstrM[31:15], bus.InstrM[11:0]};

`ifdef MEM_MISALIGN_CHECK_EN
    assign mis_store = bus.MemWriteM &&
                       (((funct3 == F3_H) && off[0]) || ((funct3 == F3_W) && (off != 2'b00)));
    assign mis_load  = is_load &&
                       ((((funct3 == F3_H) || (funct3 == F3_HU)) && off[0]) ||
                        ((funct3 == F3_W) && (off != 2'b00)));
`else
    assign mis_store = 1'b0;
    assign mis_load  = 1'b0;
`endif

    // Store data is replicated across lanes so only the lane enables depend on the offset.
    always_comb begin
        lane_we = 4'b0000;
        wdata   = {4{bus.WriteDataM[7:0]}};
        if (bus.MemWriteM && !rst && !mis_store) begin
            case (funct3)
                F3_B: lane_we = 4'b0001 << off;
                F3_H: begin
                    lane_we = off[1] ? 4'b1100 : 4'b0011;
                    wdata   = {2{bus.WriteDataM[15:0]}};
                end
                F3_W: begin
                    lane_we = 4'b1111;
                    wdata   = bus.WriteDataM;
                end
                default: lane_we = 4'b0000;
            endcase
        end
    end

    data_mem #(
        .DMEM_WORDS (DMEM_WORDS),
        .AW         (AW)
    ) u_data_mem (
        .clk   (clk),
        .addr  (word_idx),
        .we    (lane_we),
        .wdata (wdata),
        .rdata (rword)
    );

    assign rshift = rword >> {off, 3'b000};
    assign rhalf  = off[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        case (funct3)
            F3_B:    load_data = {{24{rshift[7]}}, rshift[7:0]};
            F3_BU:   load_data = {24'h000000, rshift[7:0]};
            F3_H:    load_data = {{16{rhalf[15]}}, rhalf};
            F3_HU:   load_data = {16'h0000, rhalf};
            F3_W:    load_data = rword;
            default: load_data = 32'h0000_0000;
        endcase
        if (mis_load) begin
            load_data = 32'h0000_0000;
        end
    end

    always_comb begin
        mw_next            = '0;
        mw_next.alu_result = bus.ALUResultM;
        mw_next.read_data  = load_data;
        mw_next.pc_plus4   = bus.PCPlus4M;
        mw_next.rd         = bus.RdM;
        mw_next.reg_write  = bus.RegWriteM && !mis_load;
        mw_next.result_src = bus.ResultSrcM;
        mw_next.misalign   = mis_store || mis_load;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mw_reg <= '0;
        end else begin
            mw_reg <= mw_next;
        end
    end

    assign bus.ALUResultW = mw_reg.alu_result;
    assign bus.ReadDataW  = mw_reg.read_data;
    assign bus.PCPlus4W   = mw_reg.pc_plus4;
    assign bus.RdW        = mw_reg.rd;
    assign bus.RegWriteW  = mw_reg.reg_write;
    assign bus.ResultSrcW = mw_reg.result_src;
    assign bus.MisalignW  = mw_reg.misalign;

    // Reserved select 11 falls back to the ALU result.
    always_comb begin
        case (mw_reg.result_src)
            RES_MEM: bus.ResultW = mw_reg.read_data;
            RES_PC4: bus.ResultW = mw_reg.pc_plus4;
            default: bus.ResultW = mw_reg.alu_result;
        endcase
    end

endmodule

// File: tb/tb_memory_cycle.sv
// Self-checking bench for memory_cycle: directed scenarios plus random traffic checked
// against a byte-array reference model. Honours MEM_MISALIGN_CHECK_EN like the design.
module tb_memory_cycle;
    import rv_pkg::*;

    localparam int DW = 1024;
    localparam int NB = DW * 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    memory_cycle_if bus ();

    memory_cycle #(
        .DMEM_WORDS (DW),
        .AW         (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  model [NB];
    logic [31:0] exp_alu, exp_rdata, exp_pc4, exp_res;
    logic [4:0]  exp_rd;
    logic        exp_rw, exp_mis;
    logic [1:0]  exp_rs;

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
        int ba = int'(a % NB);
        int hb = ba - (ba % 2);
        int wb = ba - (ba % 4);
        logic [31:0] v;
        if (f3 == F3_B || f3 == F3_BU) begin
            v = 32'(model[ba]);
            if (f3 == F3_B && v >= 128) v = v - 256;
        end else if (f3 == F3_H || f3 == F3_HU) begin
            v = 32'(model[hb]) + 256 * 32'(model[hb+1]);
            if (f3 == F3_H && v >= 32768) v = v - 65536;
        end else if (f3 == F3_W) begin
            v = 32'(model[wb]) + 256 * 32'(model[wb+1]) + 65536 * 32'(model[wb+2])
                + 16777216 * 32'(model[wb+3]);
        end else begin
            v = 0;
        end
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
        int ba = int'(a % NB);
        int hb = ba - (ba % 2);
        int wb = ba - (ba % 4);
        if (f3 == F3_B) begin
            model[ba] = 8'(wd % 256);
        end else if (f3 == F3_H) begin
            model[hb]   = 8'(wd % 256);
            model[hb+1] = 8'((wd / 256) % 256);
        end else if (f3 == F3_W) begin
            for (int k = 0; k < 4; k++) model[wb+k] = 8'((wd >> (8 * k)) % 256);
        end
    endtask

    // Drive one M-stage instruction, predict its W-stage outputs, clock it through.
    task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                        input logic mw, input logic [1:0] rs, input logic [4:0] rd,
                        input logic rw, input logic [31:0] pc4);
        logic [31:0] instr;
        logic        ms, ml;
        instr = $urandom;
        instr[14:12] = f3;
        bus.ALUResultM = a;
        bus.WriteDataM = wd;
        bus.PCPlus4M   = pc4;
        bus.InstrM     = instr;
        bus.RdM        = rd;
        bus.RegWriteM  = rw;
        bus.MemWriteM  = mw;
        bus.ResultSrcM = rs;
`ifdef MEM_MISALIGN_CHECK_EN
        ms = mw && ((f3 == F3_H && a[0]) || (f3 == F3_W && (a % 4) != 0));
        ml = (rs == RES_MEM) && (((f3 == F3_H || f3 == F3_HU) && a[0]) || (f3 == F3_W && (a % 4) != 0));
`else
        ms = 1'b0;
        ml = 1'b0;
`endif
        exp_alu   = a;
        exp_rdata = ml ? 32'h0 : ref_load(a, f3);
        exp_pc4   = pc4;
        exp_rd    = rd;
        exp_rw    = rw && !ml;
        exp_rs    = rs;
        exp_mis   = ms || ml;
        exp_res   = (rs == RES_MEM) ? exp_rdata : (rs == RES_PC4) ? pc4 : a;
        @(posedge clk);
        #1;
        if (mw && !ms) ref_store(a, f3, wd);
    endtask

    task automatic test_reset();
        bus.ALUResultM = 32'h40; bus.WriteDataM = 32'h1111_1111; bus.PCPlus4M = 32'h44;
        bus.InstrM = 32'h0000_2023; bus.RdM = 5'd7; bus.RegWriteM = 1'b1;
        bus.MemWriteM = 1'b1; bus.ResultSrcM = RES_MEM;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.ALUResultW, bus.ReadDataW, bus.PCPlus4W, bus.RdW, bus.RegWriteW, bus.ResultSrcW,
             bus.MisalignW} !== '0) begin
            errors++;
            $display("FAIL reset_wregs alu=%h rd=%h pc4=%h rdw=%0d rw=%b rs=%b mis=%b required all 0",
                     bus.ALUResultW, bus.ReadDataW, bus.PCPlus4W, bus.RdW, bus.RegWriteW,
                     bus.ResultSrcW, bus.MisalignW);
        end
        checks++;
        if (bus.ResultW !== 32'h0) begin
            errors++;
            $display("FAIL reset_result got %h required 00000000", bus.ResultW);
        end
        rst = 1'b0;
        step(32'h40, 32'hCAFE_F00D, F3_W, 1'b1, RES_ALU, 5'd0, 1'b0, 32'h4);
        bus.WriteDataM = 32'h1111_1111;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.ResultW !== 32'h0 || bus.MisalignW !== 1'b0) begin
            errors++;
            $display("FAIL reset_midstore result=%h mis=%b required 0/0", bus.ResultW, bus.MisalignW);
        end
        rst = 1'b0;
        step(32'h40, 32'h0, F3_W, 1'b0, RES_MEM, 5'd3, 1'b1, 32'h8);
        checks++;
        if (bus.ResultW !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL reset_nowrite got %h required cafef00d", bus.ResultW);
        end
        $display("test_reset done");
    endtask

    task automatic test_word();
        step(32'h10, 32'hDEAD_BEEF, F3_W, 1'b1, RES_ALU, 5'd0, 1'b0, 32'h100);
        step(32'h10, 32'h0, F3_W, 1'b0, RES_MEM, 5'd5, 1'b1, 32'h104);
        checks++;
        if (bus.ReadDataW !== 32'hDEAD_BEEF || bus.ResultW !== 32'hDEAD_BEEF || bus.RdW !== 5'd5) begin
            errors++;
            $display("FAIL lw_word rdata=%h result=%h rd=%0d required deadbeef/deadbeef/5",
                     bus.ReadDataW, bus.ResultW, bus.RdW);
        end
        $display("test_word done");
    endtask

    task automatic test_byte();
        step(32'h10, 32'h0, F3_W, 1'b1, RES_ALU, 5'd0, 1'b0, 32'h0);
        step(32'h13, 32'h5A5A_5A80, F3_B, 1'b1, RES_ALU, 5'd0, 1'b0, 32'h0);
        step(32'h13, 32'h0, F3_B, 1'b0, RES_MEM, 5'd1, 1'b1, 32'h0);
        checks++;
        if (bus.ResultW !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL lb got %h required ffffff80", bus.ResultW);
        end
        step(32'h13, 32'h0, F3_BU, 1'b0, RES_MEM, 5'd1, 1'b1, 32'h0);
        checks++;
        if (bus.ResultW !== 32'h0000_0080) begin
            errors++;
            $display("FAIL lbu got %h required 00000080", bus.ResultW);
        end
        step(32'h10, 32'h0, F3_W, 1'b0, RES_MEM, 5'd1, 1'b1, 32'h0);
        checks++;
        if (bus.ResultW !== 32'h8000_0000) begin
            errors++;
            $display("FAIL sb_word got %h required 80000000", bus.ResultW);
        end
        $display("test_byte done");
    endtask

    task automatic test_half();
        step(32'h20, 32'h1234_ABCD, F3_W, 1'b1, RES_ALU, 5'd0, 1'b0, 32'h0);
        step(32'h22, 32'h7777_8001, F3_H, 1'b1, RES_ALU, 5'd0, 1'b0, 32'h0);
        step(32'h22, 32'h0, F3_H, 1'b0, RES_MEM, 5'd2, 1'b1, 32'h0);
        checks++;
        if (bus.ResultW !== 32'hFFFF_8001) begin
            errors++;
            $display("FAIL lh got %h required ffff8001", bus.ResultW);
        end
        step(32'h22, 32'h0, F3_HU, 1'b0, RES_MEM, 5'd2, 1'b1, 32'h0);
        checks++;
        if (bus.ResultW !== 32'h0000_8001) begin
            errors++;
            $display("FAIL lhu got %h required 00008001", bus.ResultW);
        end
        step(32'h20, 32'h0, F3_W, 1'b0, RES_MEM, 5'd2, 1'b1, 32'h0);
        checks++;
        if (bus.ResultW !== 32'h8001_ABCD) begin
            errors++;
            $display("FAIL sh_lowhalf got %h required 8001abcd", bus.ResultW);
        end
        $display("test_half done");
    endtask

    task automatic test_wrap();
        step(32'(DW * 4 + 4), 32'h1234_5678, F3_W, 1'b1, RES_ALU, 5'd0, 1'b0, 32'h0);
        step(32'h4, 32'h0, F3_W, 1'b0, RES_MEM, 5'd9, 1'b1, 32'h0);
        checks++;
        if (bus.ReadDataW !== 32'h1234_5678) begin
            errors++;
            $display("FAIL wrap got %h required 12345678", bus.ReadDataW);
        end
        $display("test_wrap done");
    endtask

    task automatic test_misalign();
        step(32'h10, 32'h55AA_55AA, F3_W, 1'b1, RES_ALU, 5'd0, 1'b0, 32'h0);
        step(32'h11, 32'h9999_9999, F3_W, 1'b1, RES_ALU, 5'd0, 1'b0, 32'h0);
`ifdef MEM_MISALIGN_CHECK_EN
        checks++;
        if (bus.MisalignW !== 1'b1) begin
            errors++;
            $display("FAIL mis_store_flag got %b required 1", bus.MisalignW);
        end
        step(32'h10, 32'h0, F3_W, 1'b0, RES_MEM, 5'd4, 1'b1, 32'h0);
        checks++;
        if (bus.ReadDataW !== 32'h55AA_55AA || bus.MisalignW !== 1'b0) begin
            errors++;
            $display("FAIL mis_store_mem got %h mis=%b required 55aa55aa/0", bus.ReadDataW, bus.MisalignW);
        end
        step(32'h11, 32'h0, F3_W, 1'b0, RES_MEM, 5'd4, 1'b1, 32'h0);
        checks++;
        if (bus.ReadDataW !== 32'h0 || bus.RegWriteW !== 1'b0 || bus.MisalignW !== 1'b1) begin
            errors++;
            $display("FAIL mis_load rdata=%h rw=%b mis=%b required 0/0/1",
                     bus.ReadDataW, bus.RegWriteW, bus.MisalignW);
        end
`else
        checks++;
        if (bus.MisalignW !== 1'b0) begin
            errors++;
            $display("FAIL mis_flag_off got %b required 0", bus.MisalignW);
        end
        step(32'h10, 32'h0, F3_W, 1'b0, RES_MEM, 5'd4, 1'b1, 32'h0);
        checks++;
        if (bus.ReadDataW !== 32'h9999_9999) begin
            errors++;
            $display("FAIL aligned_down_store got %h required 99999999", bus.ReadDataW);
        end
        step(32'h11, 32'h0, F3_W, 1'b0, RES_MEM, 5'd4, 1'b1, 32'h0);
        checks++;
        if (bus.ReadDataW !== 32'h9999_9999 || bus.RegWriteW !== 1'b1) begin
            errors++;
            $display("FAIL aligned_down_load got %h rw=%b required 99999999/1", bus.ReadDataW, bus.RegWriteW);
        end
`endif
        step(32'h300, 32'h0, F3_W, 1'b0, RES_PC4, 5'd1, 1'b1, 32'h104);
        checks++;
        if (bus.ResultW !== 32'h104) begin
            errors++;
            $display("FAIL result_pc4 got %h required 00000104", bus.ResultW);
        end
        $display("test_misalign done");
    endtask

    task automatic test_random();
        for (int w = 0; w < 64; w++) step(32'(w * 4), $urandom, F3_W, 1'b1, RES_ALU, 5'd0, 1'b0, 32'h0);
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 255)) + (32'($urandom_range(0, 3)) << 12);
            step(a, $urandom, 3'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0),
                 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom);
            checks++;
            if (bus.ReadDataW !== exp_rdata || bus.ResultW !== exp_res) begin
                errors++;
                $display("FAIL rnd_data n=%0d rdata=%h result=%h required %h/%h",
                         n, bus.ReadDataW, bus.ResultW, exp_rdata, exp_res);
            end
            checks++;
            if ({bus.ALUResultW, bus.PCPlus4W, bus.RdW, bus.RegWriteW, bus.ResultSrcW, bus.MisalignW} !==
                {exp_alu, exp_pc4, exp_rd, exp_rw, exp_rs, exp_mis}) begin
                errors++;
                $display("FAIL rnd_ctrl n=%0d alu=%h pc4=%h rd=%0d rw=%b rs=%b mis=%b required %h/%h/%0d/%b/%b/%b",
                         n, bus.ALUResultW, bus.PCPlus4W, bus.RdW, bus.RegWriteW, bus.ResultSrcW,
                         bus.MisalignW, exp_alu, exp_pc4, exp_rd, exp_rw, exp_rs, exp_mis);
            end
        end
        $display("test_random done");
    endtask

    initial begin
        for (int i = 0; i < NB; i++) model[i] = 8'h00;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_wrap();
        test_misalign();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
